// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial add/subtract controller:
// FSM state encodings and the default operand width.
package serial_add_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/onebitadder.sv
// One-bit full-adder cell; purely combinational, shared by the serial
// controller across all bit positions.
module onebitadder (
    input  logic d1,
    input  logic d2,
    input  logic Cin,
    output logic out,
    output logic Co
);

    assign out = d1 ^ d2 ^ Cin;
    assign Co  = (d1 & d2) | (d1 & Cin) | (d2 & Cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit add/subtract controller: streams operands LSB first
// through a single full-adder cell with one registered carry.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   shift_a_reg, shift_b_reg, sum_reg;
    logic [WIDTH-1:0]   b_load;
    logic [CNT_W-1:0]   count_reg;
    logic               carry_reg, cout_reg, overflow_reg;
    logic               fa_out, fa_co;
    logic               accept, last_bit;

    // Subtraction is a + ~b + 1: invert b here, the +1 enters as the initial carry.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_b_load
            assign b_load[gi] = b[gi] ^ sub;
        end
    endgenerate

    assign accept   = (state_reg == ST_IDLE) && start;
    assign last_bit = (count_reg == CNT_W'(WIDTH - 1));

    onebitadder u_fa (
        .d1  (shift_a_reg[0]),
        .d2  (shift_b_reg[0]),
        .Cin (carry_reg),
        .out (fa_out),
        .Co  (fa_co)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN:  if (last_bit) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_reg == ST_RUN);
        done = (state_reg == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_a_reg  <= '0;
            shift_b_reg  <= '0;
            sum_reg      <= '0;
            count_reg    <= '0;
            carry_reg    <= 1'b0;
            cout_reg     <= 1'b0;
            overflow_reg <= 1'b0;
        end else if (accept) begin
            shift_a_reg <= a;
            shift_b_reg <= b_load;
            sum_reg     <= '0;
            count_reg   <= '0;
            carry_reg   <= sub;
        end else if (state_reg == ST_RUN) begin
            shift_a_reg <= shift_a_reg >> 1;
            shift_b_reg <= shift_b_reg >> 1;
            sum_reg     <= {fa_out, sum_reg[WIDTH-1:1]};
            carry_reg   <= fa_co;
            count_reg   <= count_reg + 1'b1;
            // carry_reg still holds the carry into the MSB on this edge.
            if (last_bit) begin
                cout_reg     <= fa_co;
                overflow_reg <= carry_reg ^ fa_co;
            end
        end
    end

    assign sum      = sum_reg;
    assign cout     = cout_reg;
    assign overflow = overflow_reg;

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial add/subtract controller that time-shares a single one-bit full-adder cell across a WIDTH-bit operation, one bit per clock, LSB first. Accepts operands on a start strobe, runs WIDTH iterations through the cell with a registered carry, then presents the sum, carry-out and signed overflow with a one-cycle done pulse. Sits between the CPU control logic and the full-adder cell as a low-area ALU add path.

Parameters:
WIDTH, 8, operand/result width in bits; legal range >= 2
CNT_W, $clog2(WIDTH), bit-iteration counter width (derived, not overridden)

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
sub  input  1  0 = a+b, 1 = a-b (two's complement); sampled with start
a  input  WIDTH  operand A; sampled with start
b  input  WIDTH  operand B; sampled with start
busy  output  1  high while iterating (RUN)
done  output  1  one-cycle pulse: result valid
sum  output  WIDTH  result; held stable from done until next accepted start
cout  output  1  carry out of MSB (for sub: 1 = no borrow)
overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- One clock; reset synchronous, active-high. On reset: state IDLE; busy=0, done=0, sum=0, cout=0, overflow=0, carry/counter/shift registers 0.
- States: IDLE, RUN, DONE (three-state FSM, registered outputs).
- IDLE: if start=1 at edge k -> load shift_a=a, shift_b = sub ? ~b : b, carry=sub, count=0, sum cleared; go RUN. Else stay.
- RUN: each edge, cell inputs d1=shift_a[0], d2=shift_b[0], Cin=carry. Cell out shifted into sum from MSB side (sum <= {out, sum[WIDTH-1:1]}); carry <= Co; shift_a/shift_b shift right 1; count++.
- When count == WIDTH-1 at an edge (bit WIDTH-1 processed): capture cout=Co, overflow=carry XOR Co (carry = carry into MSB); go DONE.
- Latency: start sampled at edge k -> done high in the cycle after edge k+WIDTH, exactly one cycle; cleared at edge k+WIDTH+1 (-> IDLE).
- busy=1 exactly in RUN (WIDTH cycles); busy=0 in IDLE and DONE.
- start while in RUN or DONE ignored (no queuing). Operand/sub changes after acceptance have no effect.
- sum/cout/overflow are unchanged in IDLE and DONE; they are modified only while iterating or by reset. An accepted start clears sum immediately; cout/overflow are updated at the final RUN edge.
- Reset mid-RUN or in DONE: abort, IDLE next cycle, all outputs 0, no done pulse.
- Full-adder cell is purely combinational; the single carry flop is the only carry storage. Arithmetic is modulo 2^WIDTH.

Decomposition:
- Shared package/include: state encodings (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2) and the default WIDTH constant.
- One sub-module: the existing onebitadder cell, instantiated once as the datapath (d1, d2, Cin -> out, Co). FSM, counter, shifters and carry flop stay in serial_add_ctrl.

Test Plan:
- WIDTH=8, a=0x25, b=0x1A, sub=0, start at edge k -> busy high for 8 cycles; done pulses after edge k+8; sum=0x3F, cout=0, overflow=0.
- a=0xFF, b=0x01, sub=0 -> sum=0x00, cout=1, overflow=0. a=0x7F, b=0x01, sub=0 -> sum=0x80, cout=0, overflow=1.
- a=0x05, b=0x07, sub=1 -> sum=0xFE, cout=0 (borrow), overflow=0. a=0x80, b=0x01, sub=1 -> sum=0x7F, cout=1, overflow=1.
- Start 0x10+0x01; mid-RUN pulse start with a=0xAA, b=0x55 and change a/b -> ignored; result sum=0x11, done exactly once, 8 busy cycles.
- Reset asserted at 4th RUN cycle -> next cycle IDLE, busy=0, done never pulses, sum=0, cout=0, overflow=0; new start 0x03+0x04 -> sum=0x07 after 8 RUN cycles.
- Back-to-back: start held high continuously -> operations start only from IDLE (one op per WIDTH+2 cycles), every done a single cycle, sum stable between done and next accepted start.
